vga_dram_arbiter: RTL and testbench

- Two-master, one-slave Avalon-MM arbiter sharing the 32-bit SDRAM controller between VGA scanout prefetch (m0, read-only, high priority) and the draw engine (m1, read/write).
- Sits between both masters and the SDRAM controller slave inside the nios2 system, on the system clock.
- Holds a grant for a whole burst.
- Bounds m1 starvation with a consecutive-grant limit.

---
 rtl/vga_dram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vga_dram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller: VGA scanout (m0) vs draw engine (m1).
// Optional statistics counters are enabled by defining VGA_DRAM_ARBITER_STATS_EN.
module vga_dram_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [BURST_W-1:0]  m1_burstcount,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
`ifdef VGA_DRAM_ARBITER_STATS_EN
    ,
    input  logic                stat_clear,
    output logic [31:0]         stat_m0_grants,
    output logic [31:0]         stat_m1_grants,
    output logic [31:0]         stat_m1_wait_cycles
`endif
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    logic [1:0]         state;
    logic               owner;
    logic [BURST_W-1:0] beats;
    logic               wr_active;
    logic [SC_W-1:0]    starve;

    logic               m0_req;
    logic               m1_req;
    logic               pick_m1;
    logic               grant;
    logic               in_cmd;
    logic               in_rdata;
    logic [BURST_W-1:0] m0_bc;
    logic [BURST_W-1:0] m1_bc;
    logic [BURST_W-1:0] own_bc;
    logic               cmd_rd;
    logic               cmd_wr;
    logic               wr_last;

    assign m0_req   = m0_read;
    assign m1_req   = m1_read | m1_write;
    assign pick_m1  = m1_req & (!m0_req | (starve == SC_W'(STARVE_LIMIT)));
    assign grant    = (state == ST_IDLE) & (m0_req | m1_req);
    assign in_cmd   = (state == ST_CMD);
    assign in_rdata = (state == ST_RDATA);

    // A zero burstcount is a single beat
    assign m0_bc  = (m0_burstcount == '0) ? BURST_W'(1) : m0_burstcount;
    assign m1_bc  = (m1_burstcount == '0) ? BURST_W'(1) : m1_burstcount;
    assign own_bc = owner ? m1_bc : m0_bc;

    // Write wins over a simultaneous m1 read; no reads once a write burst started
    assign cmd_wr  = in_cmd & owner & m1_write;
    assign cmd_rd  = in_cmd & !wr_active & (owner ? (m1_read & !m1_write) : m0_read);
    assign wr_last = wr_active ? (beats == BURST_W'(1)) : (own_bc == BURST_W'(1));

    always_comb begin
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        s_burstcount = '0;
        s_read       = cmd_rd;
        s_write      = cmd_wr;
        if (in_cmd) begin
            s_address    = owner ? m1_address : m0_address;
            s_writedata  = owner ? m1_writedata : '0;
            s_byteenable = owner ? m1_byteenable : '1;
            s_burstcount = own_bc;
        end
    end

    assign m0_waitrequest   = (in_cmd && !owner) ? s_waitrequest : 1'b1;
    assign m1_waitrequest   = (in_cmd && owner) ? s_waitrequest : 1'b1;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = in_rdata & !owner & s_readdatavalid;
    assign m1_readdatavalid = in_rdata & owner & s_readdatavalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            beats     <= '0;
            wr_active <= 1'b0;
            starve    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner     <= pick_m1;
                        state     <= ST_CMD;
                        wr_active <= 1'b0;
                        if (pick_m1 || !m1_req) begin
                            starve <= '0;
                        end else if (starve != SC_W'(STARVE_LIMIT)) begin
                            starve <= starve + SC_W'(1);
                        end
                    end
                end
                ST_CMD: begin
                    if (cmd_wr) begin
                        if (!s_waitrequest) begin
                            if (wr_last) begin
                                state     <= ST_IDLE;
                                wr_active <= 1'b0;
                            end else begin
                                beats     <= (wr_active ? beats : own_bc) - BURST_W'(1);
                                wr_active <= 1'b1;
                            end
                        end
                    end else if (cmd_rd) begin
                        if (!s_waitrequest) begin
                            beats <= own_bc;
                            state <= ST_RDATA;
                        end
                    end else if (!wr_active) begin
                        // Owner withdrew before anything was accepted
                        state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (s_readdatavalid) begin
                        beats <= beats - BURST_W'(1);
                        if (beats == BURST_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VGA_DRAM_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_m0_grants      <= '0;
            stat_m1_grants      <= '0;
            stat_m1_wait_cycles <= '0;
        end else if (stat_clear) begin
            stat_m0_grants      <= '0;
            stat_m1_grants      <= '0;
            stat_m1_wait_cycles <= '0;
        end else begin
            if (grant && !pick_m1) begin
                stat_m0_grants <= stat_m0_grants + 32'd1;
            end
            if (grant && pick_m1) begin
                stat_m1_grants <= stat_m1_grants + 32'd1;
            end
            if (m1_req && !((state != ST_IDLE) && owner)) begin
                stat_m1_wait_cycles <= stat_m1_wait_cycles + 32'd1;
            end
        end
    end
`endif

    a_m1_rd_wr_exclusive: assert property (
        @(posedge clk) disable iff (!reset_n) !(m1_read && m1_write)
    );

endmodule

// File: tb/tb_vga_dram_arbiter.sv
// Directed bench for vga_dram_arbiter: bursts, priority/starvation, reset abort, zero burstcount.
// Statistics checks run when VGA_DRAM_ARBITER_STATS_EN is defined.
module tb_vga_dram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [22:0] m0_address;
    logic        m0_read;
    logic [3:0]  m0_burstcount;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [22:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic [3:0]  m1_burstcount;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [22:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic [3:0]  s_burstcount;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
`ifdef VGA_DRAM_ARBITER_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_m0_grants;
    logic [31:0] stat_m1_grants;
    logic [31:0] stat_m1_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int n0;
    int n1;
    int acc;
    int ng;
    logic seq [6];
    logic exp_seq [6];

    always #5 clk = ~clk;

    vga_dram_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_burstcount    (m0_burstcount),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_burstcount    (m1_burstcount),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_burstcount     (s_burstcount),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid)
`ifdef VGA_DRAM_ARBITER_STATS_EN
        ,
        .stat_clear          (stat_clear),
        .stat_m0_grants      (stat_m0_grants),
        .stat_m1_grants      (stat_m1_grants),
        .stat_m1_wait_cycles (stat_m1_wait_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef VGA_DRAM_ARBITER_STATS_EN
    task automatic rd_txn(input bit use_m1, input logic [22:0] a);
        @(posedge clk); #1;
        if (use_m1) begin
            m1_read = 1'b1; m1_address = a; m1_burstcount = 4'd1;
        end else begin
            m0_read = 1'b1; m0_address = a; m0_burstcount = 4'd1;
        end
        s_waitrequest = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_read = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b1;
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_burstcount = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = '0; m1_byteenable = '0; m1_burstcount = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
`ifdef VGA_DRAM_ARBITER_STATS_EN
        stat_clear = 1'b0;
`endif
        exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
        exp_seq[3] = 1'b0; exp_seq[4] = 1'b1; exp_seq[5] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_s_addr", s_address, 0);
        chk("rst_s_bc", s_burstcount, 0);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // m0 burst-8 read with 2 waitrequest cycles
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 23'h000100; m0_burstcount = 4'd8;
        s_waitrequest = 1'b1;
        @(negedge clk);
        chk("t1_idle_no_cmd", s_read, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_s_read", s_read, 1);
        chk("t1_s_addr", s_address, 32'h100);
        chk("t1_s_bc", s_burstcount, 8);
        chk("t1_m0_wait", m0_waitrequest, 1);
        chk("t1_m1_wait", m1_waitrequest, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_s_read2", s_read, 1);
        @(posedge clk); #1;
        s_waitrequest = 1'b0;
        @(negedge clk);
        chk("t1_m0_wait_low", m0_waitrequest, 0);
        @(posedge clk); #1;
        m0_read = 1'b0; s_waitrequest = 1'b1;
        @(negedge clk);
        chk("t1_rdata_cmd_off", s_read, 0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            s_readdatavalid = 1'b1;
            s_readdata = 32'hA000_0000 + i;
            @(negedge clk);
            if (m0_readdatavalid) n0++;
            if (m1_readdatavalid) n1++;
            chk("t1_rdata", m0_readdata, 32'hA000_0000 + i);
        end
        chk("t1_m0_beats", n0, 8);
        chk("t1_m1_beats", n1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_idle_drop", m0_readdatavalid, 0);
        chk("t1_idle_wait", m0_waitrequest, 1);
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;

        // m1 burst-4 write, waitrequest toggling, m0 raised mid-burst
        @(posedge clk); #1;
        m1_write = 1'b1; m1_address = 23'h002000; m1_burstcount = 4'd4;
        m1_writedata = 32'hD0D0_0000; m1_byteenable = 4'b0001;
        s_waitrequest = 1'b1;
        @(negedge clk);
        chk("t2_idle_no_cmd", s_write, 0);
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            @(posedge clk); #1;
            m1_writedata = 32'hD0D0_0000 + acc;
            m1_byteenable = 4'b0001 << acc;
            s_waitrequest = (c % 2 == 0);
            if (c == 2) begin
                m0_read = 1'b1; m0_address = 23'h000300; m0_burstcount = 4'd1;
            end
            @(negedge clk);
            chk("t2_s_write", s_write, 1);
            chk("t2_s_addr", s_address, 32'h2000);
            chk("t2_s_bc", s_burstcount, 4);
            chk("t2_wdata", s_writedata, 32'hD0D0_0000 + acc);
            chk("t2_be", s_byteenable, 32'(4'b0001 << acc));
            chk("t2_m1_wait", m1_waitrequest, (c % 2 == 0));
            chk("t2_m0_stalled", m0_waitrequest, 1);
            if (!s_waitrequest) acc++;
        end
        chk("t2_beats", acc, 4);
        @(posedge clk); #1;
        m1_write = 1'b0;
        @(negedge clk);
        chk("t2_idle_s_write", s_write, 0);
        chk("t2_idle_s_read", s_read, 0);
        chk("t2_idle_m0_wait", m0_waitrequest, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_m0_granted", s_read, 1);
        chk("t2_m0_addr", s_address, 32'h300);
        @(posedge clk); #1;
        m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 32'h0000_BEEF;
        @(negedge clk);
        chk("t2_m0_rdv", m0_readdatavalid, 1);
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;

        // Both masters requesting continuously: starvation limit
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 23'h0000A0; m0_burstcount = 4'd1;
        m1_read = 1'b1; m1_address = 23'h0000B0; m1_burstcount = 4'd1;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (s_read) begin
                seq[ng] = (s_address == 23'h0000B0);
                ng++;
            end
            @(posedge clk); #1;
        end
        m0_read = 1'b0; m1_read = 1'b0;
        chk("t3_grants", ng, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_grant%0d", k), seq[k], exp_seq[k]);
        end
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;

        // Reset during RDATA with 3 beats outstanding
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 23'h000400; m0_burstcount = 4'd4;
        s_waitrequest = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_read = 1'b0; s_readdatavalid = 1'b1;
        @(negedge clk);
        chk("t4_beat1", m0_readdatavalid, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_m0_wait", m0_waitrequest, 1);
        chk("t4_rst_m1_wait", m1_waitrequest, 1);
        chk("t4_rst_s_read", s_read, 0);
        chk("t4_rst_rdv", m0_readdatavalid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t4_late_drop", m0_readdatavalid, 0);
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;

        // Zero burstcount single write after reset
        m1_write = 1'b1; m1_address = 23'h000555; m1_burstcount = 4'd0;
        m1_writedata = 32'h1234_5678; m1_byteenable = 4'hC;
        @(negedge clk);
        chk("t5_idle", s_write, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_s_write", s_write, 1);
        chk("t5_s_bc", s_burstcount, 1);
        chk("t5_s_addr", s_address, 32'h555);
        chk("t5_wdata", s_writedata, 32'h1234_5678);
        chk("t5_be", s_byteenable, 32'hC);
        chk("t5_m1_wait", m1_waitrequest, 0);
        @(posedge clk); #1;
        m1_write = 1'b0;
        @(negedge clk);
        chk("t5_done_write", s_write, 0);
        chk("t5_done_wait", m1_waitrequest, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_idle_after", s_write, 0);

`ifdef VGA_DRAM_ARBITER_STATS_EN
        @(posedge clk); #1;
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        @(negedge clk);
        chk("st_clr_m0", stat_m0_grants, 0);
        chk("st_clr_m1", stat_m1_grants, 0);
        chk("st_clr_wait", stat_m1_wait_cycles, 0);
        rd_txn(1'b0, 23'h10);
        rd_txn(1'b1, 23'h20);
        rd_txn(1'b0, 23'h30);
        rd_txn(1'b1, 23'h40);
        rd_txn(1'b0, 23'h50);
        @(negedge clk);
        chk("st_m0", stat_m0_grants, 3);
        chk("st_m1", stat_m1_grants, 2);
        chk("st_wait", stat_m1_wait_cycles, 2);
        @(posedge clk); #1;
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        @(negedge clk);
        chk("st_clr2_m0", stat_m0_grants, 0);
        chk("st_clr2_m1", stat_m1_grants, 0);
        chk("st_clr2_wait", stat_m1_wait_cycles, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
